round_sequencer: RTL and testbench
==================================

Name: round_sequencer

Overview:
- Synchronous game controller for the spy-mangler datapath. Replaces the button-clocked pointer logic with a single-clock FSM.
- Sequences player1 code entry into ram32x10, fetches each stored code as player2's compare value, and scores player2's attempts.
- Issues a one-cycle strobe with a correct flag to the translator/VGA path.
- Sits between the KEY inputs and the player1, player2, ram32x10 and translator instances in main.

Parameters:
- ADDR_W, 4, RAM address width; capacity is 2**ADDR_W codes.
- DATA_W, 10, morse code word width.
- READ_LAT, 2, cycles from ram_addr valid to ram_q valid.

Ports:
- clock  in  1  system clock (CLOCK_50 domain).
- reset  in  1  asynchronous, active-high reset.
- next_n  in  1  raw active-low "next" button.
- done_n  in  1  raw active-low "done" button.
- p1_value  in  DATA_W  player1's current accumulated code.
- p2_correct  in  2  player2 verdict: 01 correct, 10 incorrect, 00 none.
- ram_q  in  DATA_W  RAM read data.
- ram_addr  out  ADDR_W  RAM address.
- ram_data  out  DATA_W  RAM write data.
- ram_wren  out  1  RAM write enable, one-cycle pulse.
- p1_reset_n  out  1  active-low clear pulse to player1.
- p2_reset_n  out  1  active-low clear pulse to player2.
- p1_active  out  1  high in P1_ENTRY.
- p2_active  out  1  high in P2_ENTRY.
- compare_value  out  DATA_W  code player2 must match.
- code_count  out  ADDR_W+1  number of codes stored.
- p2_index  out  ADDR_W  code currently being cracked.
- score  out  ADDR_W+1  number of correct player2 attempts.
- state  out  3  current state encoding, for the hex display.
- game_over  out  1  high in RESULT.
- vga_strobe  out  1  one-cycle pulse per player2 commit.
- vga_correct  out  1  verdict held from the last commit.

Behaviour:
- Reset values: state=IDLE; all counters, compare_value, ram_* and vga_* = 0; p1_reset_n=p2_reset_n=1; both button synchronizers = 1.
- Buttons: each passes through a 2-FF synchronizer, then a falling-edge detector producing a one-cycle press pulse. A held button yields exactly one pulse.
- Press priority: a done press and a next press in the same cycle → done wins and next is discarded. Presses in states that do not consume them are dropped, not queued.
- State encodings: IDLE=0, P1_ENTRY=1, P1_WRITE=2, P2_FETCH=3, P2_ENTRY=4, P2_CHECK=5, RESULT=6.
- IDLE:
  - done press → P1_ENTRY.
  - Clear code_count, p2_index and score.
  - p1_reset_n low for 1 cycle.
- P1_ENTRY:
  - next press with code_count < 2**ADDR_W → latch p1_value into ram_data, go to P1_WRITE.
  - next press when full → ignored.
  - done press with code_count==0 → RESULT.
  - done press with code_count>0 → p2_index=0, go to P2_FETCH.
- P1_WRITE (exactly 1 cycle):
  - ram_wren=1 and ram_addr=code_count[ADDR_W-1:0].
  - code_count+1 and p1_reset_n low in the same cycle, then → P1_ENTRY.
- P2_FETCH:
  - ram_addr=p2_index, held READ_LAT cycles (internal wait counter).
  - In the last cycle, compare_value<=ram_q and p2_reset_n low for 1 cycle, then → P2_ENTRY.
- P2_ENTRY:
  - next press → P2_CHECK.
  - done press → RESULT (forfeit; remaining codes are unscored).
- P2_CHECK (exactly 1 cycle):
  - vga_strobe=1 and vga_correct<=(p2_correct==2'b01).
  - score+1 if correct.
  - If p2_index+1==code_count → RESULT; else p2_index+1 → P2_FETCH.
- RESULT: game_over=1. Counters and score are held. A done press → IDLE.
- ram_wren must be 0 in every state except P1_WRITE.
- code_count saturates at 2**ADDR_W; ram_addr never wraps onto an already written entry.
- Reset asserted mid-operation returns immediately to IDLE reset values. A write pulse that was in flight is dropped.

Test Plan:
- Reset, then done press → state=1, p1_reset_n low exactly 1 cycle, code_count=0.
- In P1 with p1_value=10'h155, next press → ram_wren high 1 cycle at addr 0 with data 155; code_count=1.
- Store 3 codes, done press → FETCH holds addr 0 for 2 cycles, compare_value=first code, state=4. Three commits with p2_correct=01,10,01 → score=2, three vga_strobes, state=6.
- Write 16 codes, then a 17th next press → no ram_wren, code_count stays 16.
- next and done pulsed in the same cycle in P1_ENTRY with count=2 → no write, state=3. done with count=0 → state=6.
- A 40-cycle next hold → exactly one write. Reset mid-P2_FETCH → state=0, score=0, no spurious strobe.

Source files
------------

// File: rtl/round_sequencer.sv
// round_sequencer: single-clock game FSM that stores player1 codes in RAM,
// replays them as player2 targets, scores attempts and strobes the VGA path.
module round_sequencer #(
   parameter int ADDR_W   = 4,
   parameter int DATA_W   = 10,
   parameter int READ_LAT = 2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              next_n,
   input  logic              done_n,
   input  logic [DATA_W-1:0] p1_value,
   input  logic [1:0]        p2_correct,
   input  logic [DATA_W-1:0] ram_q,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_data,
   output logic              ram_wren,
   output logic              p1_reset_n,
   output logic              p2_reset_n,
   output logic              p1_active,
   output logic              p2_active,
   output logic [DATA_W-1:0] compare_value,
   output logic [ADDR_W:0]   code_count,
   output logic [ADDR_W-1:0] p2_index,
   output logic [ADDR_W:0]   score,
   output logic [2:0]        state,
   output logic              game_over,
   output logic              vga_strobe,
   output logic              vga_correct
);
   typedef enum logic [2:0] {
      IDLE = 3'd0, P1_ENTRY = 3'd1, P1_WRITE = 3'd2, P2_FETCH = 3'd3,
      P2_ENTRY = 3'd4, P2_CHECK = 3'd5, RESULT = 3'd6
   } state_t;
   localparam int WW = $clog2(READ_LAT + 1);
   state_t state_q, state_d;
   logic [2:0] next_sync_q, done_sync_q;
   logic [ADDR_W:0] code_count_q, code_count_d, score_q, score_d;
   logic [ADDR_W-1:0] p2_index_q, p2_index_d;
   logic [DATA_W-1:0] compare_q, compare_d, ram_data_q, ram_data_d;
   logic vga_correct_q, vga_correct_d, p1_rst_n_q, p1_rst_n_d, p2_rst_n_q, p2_rst_n_d;
   logic [WW-1:0] wait_q, wait_d;
   logic next_p, done_p, hit;
   // bits [1:0] synchronize, bit [2] remembers the previous level for edge detection
   assign next_p = next_sync_q[2] & ~next_sync_q[1];
   assign done_p = done_sync_q[2] & ~done_sync_q[1];
   assign hit    = p2_correct == 2'b01;
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         next_sync_q   <= '1;
         done_sync_q   <= '1;
         code_count_q  <= '0;
         score_q       <= '0;
         p2_index_q    <= '0;
         compare_q     <= '0;
         ram_data_q    <= '0;
         vga_correct_q <= 1'b0;
         p1_rst_n_q    <= 1'b1;
         p2_rst_n_q    <= 1'b1;
         wait_q        <= '0;
      end else begin
         state_q       <= state_d;
         next_sync_q   <= {next_sync_q[1:0], next_n};
         done_sync_q   <= {done_sync_q[1:0], done_n};
         code_count_q  <= code_count_d;
         score_q       <= score_d;
         p2_index_q    <= p2_index_d;
         compare_q     <= compare_d;
         ram_data_q    <= ram_data_d;
         vga_correct_q <= vga_correct_d;
         p1_rst_n_q    <= p1_rst_n_d;
         p2_rst_n_q    <= p2_rst_n_d;
         wait_q        <= wait_d;
      end
   end
   always_comb begin
      state_d       = state_q;
      code_count_d  = code_count_q;
      score_d       = score_q;
      p2_index_d    = p2_index_q;
      compare_d     = compare_q;
      ram_data_d    = ram_data_q;
      vga_correct_d = vga_correct_q;
      p1_rst_n_d    = 1'b1;
      p2_rst_n_d    = 1'b1;
      wait_d        = '0;
      case (state_q)
         IDLE: begin
            code_count_d = '0;
            p2_index_d   = '0;
            score_d      = '0;
            if (done_p) begin
               state_d    = P1_ENTRY;
               p1_rst_n_d = 1'b0;
            end
         end
         P1_ENTRY: begin
            if (done_p) begin
               p2_index_d = '0;
               state_d    = (code_count_q == '0) ? RESULT : P2_FETCH;
            end else if (next_p && !code_count_q[ADDR_W]) begin
               ram_data_d = p1_value;
               p1_rst_n_d = 1'b0;
               state_d    = P1_WRITE;
            end
         end
         P1_WRITE: begin
            code_count_d = code_count_q + 1'b1;
            state_d      = P1_ENTRY;
         end
         P2_FETCH: begin
            if (wait_q == WW'(READ_LAT - 1)) begin
               compare_d  = ram_q;
               p2_rst_n_d = 1'b0;
               state_d    = P2_ENTRY;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         P2_ENTRY: state_d = done_p ? RESULT : next_p ? P2_CHECK : P2_ENTRY;
         P2_CHECK: begin
            vga_correct_d = hit;
            score_d       = score_q + {{ADDR_W{1'b0}}, hit};
            if (({1'b0, p2_index_q} + 1'b1) == code_count_q) begin
               state_d = RESULT;
            end else begin
               p2_index_d = p2_index_q + 1'b1;
               state_d    = P2_FETCH;
            end
         end
         RESULT: state_d = done_p ? IDLE : RESULT;
         default: state_d = IDLE;
      endcase
   end
   assign ram_addr      = (state_q == P1_WRITE) ? code_count_q[ADDR_W-1:0] : p2_index_q;
   assign ram_data      = ram_data_q;
   assign ram_wren      = state_q == P1_WRITE;
   assign p1_reset_n    = p1_rst_n_q;
   assign p2_reset_n    = p2_rst_n_q;
   assign p1_active     = state_q == P1_ENTRY;
   assign p2_active     = state_q == P2_ENTRY;
   assign compare_value = compare_q;
   assign code_count    = code_count_q;
   assign p2_index      = p2_index_q;
   assign score         = score_q;
   assign state         = state_q;
   assign game_over     = state_q == RESULT;
   assign vga_strobe    = state_q == P2_CHECK;
   assign vga_correct   = vga_correct_q;
endmodule

// File: tb/tb_round_sequencer.sv
// tb_round_sequencer: directed-vector bench with a 1-cycle registered RAM model
// and event counters for write, strobe and clear pulses.
module tb_round_sequencer;
   logic clock = 1'b0, reset = 1'b1, next_n = 1'b1, done_n = 1'b1;
   logic [9:0] p1_value = '0, ram_q_r = '0, ram_data, compare_value;
   logic [1:0] p2_correct = 2'b00;
   logic [3:0] ram_addr, p2_index;
   logic [4:0] code_count, score;
   logic [2:0] state;
   logic ram_wren, p1_reset_n, p2_reset_n, p1_active, p2_active, game_over, vga_strobe, vga_correct;
   logic [9:0] mem [16];
   int wr_cnt = 0, st_cnt = 0, p1l_cnt = 0, f0_cnt = 0, last_wa = -1, last_wd = -1;
   int n_chk = 0, n_pass = 0, snap;
   round_sequencer dut (
      .clock(clock), .reset(reset), .next_n(next_n), .done_n(done_n),
      .p1_value(p1_value), .p2_correct(p2_correct), .ram_q(ram_q_r),
      .ram_addr(ram_addr), .ram_data(ram_data), .ram_wren(ram_wren),
      .p1_reset_n(p1_reset_n), .p2_reset_n(p2_reset_n), .p1_active(p1_active),
      .p2_active(p2_active), .compare_value(compare_value), .code_count(code_count),
      .p2_index(p2_index), .score(score), .state(state), .game_over(game_over),
      .vga_strobe(vga_strobe), .vga_correct(vga_correct)
   );
   always #5 clock = ~clock;
   always @(posedge clock) begin
      if (ram_wren) begin
         wr_cnt++;
         last_wa = int'(ram_addr);
         last_wd = int'(ram_data);
         mem[ram_addr] <= ram_data;
      end
      ram_q_r <= mem[ram_addr];
      if (vga_strobe) st_cnt++;
      if (!p1_reset_n) p1l_cnt++;
      if (state == 3'd3 && ram_addr == 4'd0) f0_cnt++;
   end
   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask
   task automatic tick(input int n);
      repeat (n) @(negedge clock);
   endtask
   task automatic press(input bit d, input bit n, input int hold, input int settle);
      done_n = !d;
      next_n = !n;
      tick(hold);
      done_n = 1'b1;
      next_n = 1'b1;
      tick(settle);
   endtask
   task automatic pulse_reset();
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      tick(1);
   endtask
   initial begin
      tick(2);
      chk("rst_state", state, 0);
      chk("rst_count", code_count, 0);
      chk("rst_score", score, 0);
      chk("rst_wren", ram_wren, 0);
      chk("rst_strobe", vga_strobe, 0);
      chk("rst_p1n", p1_reset_n, 1);
      chk("rst_p2n", p2_reset_n, 1);
      chk("rst_cmp", compare_value, 0);
      reset = 1'b0;
      tick(1);
      press(0, 1, 1, 6);
      chk("idle_next_dropped", state, 0);
      snap = p1l_cnt;
      press(1, 0, 1, 6);
      chk("p1_state", state, 1);
      chk("p1_active", p1_active, 1);
      chk("p1_clear_pulse", p1l_cnt - snap, 1);
      chk("p1_count0", code_count, 0);
      snap = wr_cnt;
      p1_value = 10'h155;
      press(0, 1, 1, 6);
      chk("wr1_pulses", wr_cnt - snap, 1);
      chk("wr1_addr", last_wa, 0);
      chk("wr1_data", last_wd, 'h155);
      chk("wr1_count", code_count, 1);
      p1_value = 10'h0AA;
      press(0, 1, 1, 6);
      p1_value = 10'h3C3;
      press(0, 1, 1, 6);
      chk("wr3_count", code_count, 3);
      chk("wr3_data", last_wd, 'h3C3);
      snap = f0_cnt;
      press(1, 0, 1, 6);
      chk("fetch0_hold", f0_cnt - snap, 2);
      chk("fetch0_cmp", compare_value, 'h155);
      chk("fetch0_state", state, 4);
      chk("fetch0_p2act", p2_active, 1);
      snap = st_cnt;
      p2_correct = 2'b01;
      press(0, 1, 1, 6);
      chk("c1_vgacor", vga_correct, 1);
      chk("c1_cmp", compare_value, 'h0AA);
      chk("c1_index", p2_index, 1);
      p2_correct = 2'b10;
      press(0, 1, 1, 6);
      chk("c2_vgacor", vga_correct, 0);
      chk("c2_cmp", compare_value, 'h3C3);
      p2_correct = 2'b01;
      press(0, 1, 1, 6);
      chk("c3_score", score, 2);
      chk("c3_strobes", st_cnt - snap, 3);
      chk("c3_state", state, 6);
      chk("c3_gameover", game_over, 1);
      chk("c3_vgacor", vga_correct, 1);
      press(0, 1, 1, 6);
      chk("result_next_held", state, 6);
      press(1, 0, 1, 6);
      chk("result_to_idle", state, 0);
      press(1, 0, 1, 6);
      chk("idle_clears_score", score, 0);
      snap = wr_cnt;
      for (int i = 0; i < 16; i++) begin
         p1_value = 10'(i * 7 + 1);
         press(0, 1, 1, 6);
      end
      chk("full_writes", wr_cnt - snap, 16);
      chk("full_count", code_count, 16);
      chk("full_last_addr", last_wa, 15);
      chk("full_last_data", last_wd, 'h6A);
      snap = wr_cnt;
      press(0, 1, 1, 6);
      chk("full_no_write", wr_cnt - snap, 0);
      chk("full_count_sat", code_count, 16);
      chk("full_state", state, 1);
      pulse_reset();
      press(1, 0, 1, 6);
      p1_value = 10'h011;
      press(0, 1, 1, 6);
      p1_value = 10'h022;
      press(0, 1, 1, 6);
      chk("both_pre_count", code_count, 2);
      snap = wr_cnt;
      press(1, 1, 1, 2);
      chk("both_state_fetch", state, 3);
      tick(4);
      chk("both_no_write", wr_cnt - snap, 0);
      chk("both_cmp", compare_value, 'h011);
      snap = st_cnt;
      p2_correct = 2'b01;
      press(0, 1, 1, 3);
      chk("mid_state_fetch", state, 3);
      chk("mid_score", score, 1);
      chk("mid_strobe", st_cnt - snap, 1);
      snap = st_cnt;
      reset = 1'b1;
      tick(1);
      chk("midrst_state", state, 0);
      chk("midrst_score", score, 0);
      chk("midrst_count", code_count, 0);
      chk("midrst_strobe", vga_strobe, 0);
      reset = 1'b0;
      tick(3);
      chk("midrst_no_strobe", st_cnt - snap, 0);
      press(1, 0, 1, 6);
      press(1, 0, 1, 6);
      chk("empty_done_result", state, 6);
      press(1, 0, 1, 6);
      press(1, 0, 1, 6);
      snap = wr_cnt;
      p1_value = 10'h2F0;
      press(0, 1, 40, 6);
      chk("hold_one_write", wr_cnt - snap, 1);
      chk("hold_count", code_count, 1);
      chk("hold_data", last_wd, 'h2F0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
